conv2d_stream: RTL

- Parametrised streaming 2D convolution engine, successor to the fixed 28x28 / 3x3 input-stage convolver.
- Accepts one raster-order pixel per cycle over a valid/ready handshake.
- Buffers K-1 image lines and forms a KxK sliding window.
- Emits one signed multiply-accumulate result per "valid" window position (no padding), with a run-time writable coefficient bank.
- Sits between the pixel source and the activation/pooling stage of the filter pipeline.

---
 rtl/conv2d_stream.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/conv2d_stream.sv
// ----------------------------------------------------------------------------
// conv2d_stream
//   Streaming KxK 2D convolution engine. Raster-order pixels arrive one per
//   cycle over a valid/ready handshake. K-1 line buffers plus a KxK window
//   register form the sliding window. One signed MAC result is emitted for
//   every window position that lies fully inside the image (no padding).
//   The coefficient bank is writable at run time.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_data    in   DATA_W signed input pixel
//   in_valid   in   in_data valid
//   in_ready   out  pixel accepted this cycle when in_valid is high
//   coef_we    in   coefficient write strobe
//   coef_addr  in   coefficient index, row-major (kernel row*K + kernel col)
//   coef_data  in   COEF_W signed coefficient value
//   frame_clr  in   synchronous frame restart (drops any pending output)
//   out_data   out  ACC_W signed convolution result
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   out_last   out  marks the final output of a frame
//   busy       out  frame in progress
// ----------------------------------------------------------------------------
module conv2d_stream #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 32,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    localparam int ADDR_W = $clog2(K*K)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     frame_clr,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);

    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_W   = $clog2(IMG_H);
    localparam int NTAP    = K*K;
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int SUM_RAW = PROD_W + $clog2(NTAP) + 1;
    // Accumulate wide enough to hold the exact sum, then wrap to ACC_W.
    localparam int SUM_W   = (SUM_RAW > ACC_W) ? SUM_RAW : ACC_W;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W-1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H-1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K-1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K-1);
    localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(K-2);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic signed [COEF_W-1:0] coef    [NTAP];
    // lb[K-2] holds the previous line, lb[0] the oldest buffered line.
    logic signed [DATA_W-1:0] lb      [K-1][IMG_W];
    logic signed [DATA_W-1:0] win_p0  [K][K];
    logic signed [DATA_W-1:0] win_nxt [K][K];
    logic signed [DATA_W-1:0] col_new [K];
    logic signed [SUM_W-1:0]  sum;
    logic                     accept;
    logic                     col_end;
    logic                     frame_end;
    logic                     produce;

    function automatic logic signed [ACC_W-1:0] wrap_acc(input logic signed [SUM_W-1:0] s);
        return s[ACC_W-1:0];
    endfunction

    assign in_ready  = !out_valid || out_ready;
    // frame_clr wins over a simultaneous pixel: that pixel is discarded.
    assign accept    = in_valid && in_ready && !frame_clr;
    assign col_end   = (col == COL_LAST);
    assign frame_end = col_end && (row == ROW_LAST);
    assign produce   = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign busy      = (state != IDLE);

    // Window as it will look after the current pixel is shifted in; the MAC
    // works on this so the result registers on the accepting edge.
    always_comb begin
        for (int i = 0; i < K-1; i++) begin
            col_new[i] = lb[i][col];
        end
        col_new[K-1] = in_data;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) begin
                win_nxt[i][j] = win_p0[i][j+1];
            end
            win_nxt[i][K-1] = col_new[i];
        end
        sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                sum = sum + SUM_W'(win_nxt[i][j]) * SUM_W'(coef[i*K+j]);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_clr) begin
            state_nxt = IDLE;
        end else if (accept) begin
            if (frame_end) begin
                state_nxt = IDLE;
            end else if ((row >= ROW_FIRST) || (col_end && (row == ROW_PRIME))) begin
                state_nxt = RUN;
            end else begin
                state_nxt = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            if (frame_clr) begin
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= frame_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < NTAP; a++) begin
                coef[a] <= '0;
            end
        end else if (coef_we && (int'(coef_addr) < NTAP)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // ---- stage p0: line buffers and window register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < K-1; i++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    lb[i][c] <= '0;
                end
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_p0[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < K-2; i++) begin
                lb[i][col] <= lb[i+1][col];
            end
            lb[K-2][col] <= in_data;
            win_p0 <= win_nxt;
        end
    end

    // ---- output register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (frame_clr) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept && produce) begin
            out_valid <= 1'b1;
            out_last  <= frame_end;
            out_data  <= wrap_acc(sum);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
